bp_stream_to_lite: RTL and testbench
====================================

# bp_stream_to_lite

Converts a BP Stream memory interface into a BP Lite memory interface. It deserializes a header plus N narrow data beats into one wide message (header + full data field). It sits on the receiving end of a stream link, for example at a memory or I/O endpoint, and presents each reassembled message to a Lite consumer. It holds one message and does not pipeline messages.

## Interface
- bp_params_p, e_bp_default_cfg, processor parameter set; supplies paddr_width_p, lce_id_width_p, lce_assoc_p.
- in_data_width_p, "inv", stream beat data width in bits (narrow side).
- out_data_width_p, "inv", Lite message data width in bits (wide side); an integer multiple of in_data_width_p.
- master_p, 0, selects which message types carry multi-beat data:
  - 1 for the command side: writes are multi-beat.
  - 0 for the response side: reads are multi-beat.
- Derived values:
  - stream_words_lp = out_data_width_p/in_data_width_p.
  - in_data_bytes_lp = in_data_width_p/8.
  - cnt_width_lp = `BSG_SAFE_CLOG2(stream_words_lp)`.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- mem_header_i  in  in_mem_msg_header_width_lp  stream beat header.
- mem_data_i  in  in_data_width_p  stream beat data.
- mem_v_i  in  1  stream beat valid.
- mem_yumi_o  out  1  stream beat consumed this cycle.
- mem_o  out  out_mem_msg_width_lp  reassembled Lite message (header + data).
- mem_v_o  out  1  Lite message valid.
- mem_yumi_i  in  1  Lite consumer takes the message; asserted only when mem_v_o=1.

## Operation
- FSM states:
  - e_collect: accepting beats.
  - e_full: message held on the output.
- Beat count N is computed from the first beat's header:
  - is_wr = msg_type ∈ {e_mem_msg_wr, e_mem_msg_uc_wr}.
  - If (master_p ^ is_wr) = 1, N = 1.
  - Otherwise N = max((1<<size)/in_data_bytes_lp, 1).
  - N is registered on the first beat.
- In e_collect:
  - mem_yumi_o = mem_v_i.
  - On each accepted beat, data is written into word slot cnt of the data buffer and cnt increments.
  - On the beat with cnt==0, the full header is captured, including the address.
  - Headers of later beats are not stored. Their auto-incremented addresses are discarded.
- Last beat (cnt == N-1, accepted): the FSM goes to e_full and cnt clears to 0.
- In e_full:
  - mem_yumi_o = 0 and mem_v_o = 1.
  - mem_o.header is the captured header.
  - On mem_yumi_i, the FSM returns to e_collect.
- Data field assembly:
  - Beat 0 sits at bits [in_data_width_p-1:0], beat k at slot k.
  - Slots k ≥ N are filled by replication: slot k = beat (k mod N).
  - Sub-block messages therefore present the standard BP replicated data pattern.
- Arithmetic:
  - cnt is cnt_width_lp bits, 0..stream_words_lp-1.
  - N-1 is compared at cnt width. N = stream_words_lp must not overflow, so N is stored as N-1.
- Simulation-only assertions:
  - (1<<size) ≤ out_data_width_p/8.
  - msg_type and size of beats 1..N-1 match beat 0.
  - mem_yumi_i is never asserted without mem_v_o.
  - in_data_width_p divides out_data_width_p.

## Timing
- Reset, the cycle after reset_i is sampled high:
  - State is e_collect, cnt=0, mem_v_o=0.
  - mem_yumi_o=0 while reset_i=1.
  - Buffer contents are don't-care.
- Reset mid-message discards the partial beats. The next beat after reset is treated as beat 0.
- mem_yumi_o is combinational from mem_v_i and the registered state. There is no path from mem_yumi_i to mem_yumi_o.
- Latency:
  - mem_v_o rises in the cycle after the last beat is accepted.
  - A 1-beat message yields mem_v_o one cycle after its beat is accepted.
- Throughput: after mem_yumi_i, the first beat of the next message is accepted no earlier than the following cycle. There is one bubble per message. This is intended.
- mem_o is stable while mem_v_o=1.
- Stream input may stall between beats at any time. cnt and the buffer hold their values.

## Test plan
- Parameters for all tests: in=64, out=512, master_p=1.
- Write, size=6 (64B), 8 beats, data 0x1..0x8, addr 0x8000_0000 on beat 0 (later beats carry +8 increments):
  - mem_v_o=1 exactly one cycle after beat 8 is accepted.
  - Data = {0x8,...,0x1}, beat 0 at the LSBs.
  - Header addr = 0x8000_0000.
- Read, size=6, 1 beat:
  - mem_v_o one cycle after acceptance.
  - Header passes through unchanged.
- Write, size=3, 1 beat 0xDEADBEEF_CAFEF00D: data = that word replicated 8 times.
- Write, size=4, beats A then B with 3 idle cycles between them: data = {B,A,B,A,B,A,B,A}, and mem_yumi_o is high only on the 2 valid cycles.
- Backpressure:
  - Hold mem_yumi_i=0 for 5 cycles with the next message's beat 0 presented: mem_yumi_o=0 throughout and mem_o stays stable.
  - After mem_yumi_i, beat 0 is accepted the next cycle.
- Reset after 3 of 8 beats, then a fresh 8-beat write with new data: the output contains only the new data and the new address.

Source files
------------

// File: rtl/bp_stream_to_lite_if.sv
// Stream-beat input and reassembled Lite-message output of bp_stream_to_lite.
// Header layout, LSB first: msg_type[3:0], addr, size[2:0], payload.
interface bp_stream_to_lite_if #(
  parameter int hdr_width_p      = 54,
  parameter int in_data_width_p  = 64,
  parameter int out_data_width_p = 512
);
  logic [hdr_width_p-1:0]                  mem_header_i;
  logic [in_data_width_p-1:0]              mem_data_i;
  logic                                    mem_v_i;
  logic                                    mem_yumi_o;
  logic [hdr_width_p+out_data_width_p-1:0] mem_o;
  logic                                    mem_v_o;
  logic                                    mem_yumi_i;

  modport slave (
    input  mem_header_i, mem_data_i, mem_v_i, mem_yumi_i,
    output mem_yumi_o, mem_o, mem_v_o
  );

  modport master (
    output mem_header_i, mem_data_i, mem_v_i, mem_yumi_i,
    input  mem_yumi_o, mem_o, mem_v_o
  );
endinterface

// File: rtl/bp_stream_to_lite.sv
// Deserializes a BP stream (header + N narrow beats) into one wide Lite message.
// Holds a single message; mem_o = {header, data} with beat 0 at data LSBs.
module bp_stream_to_lite #(
  parameter int paddr_width_p    = 40,
  parameter int lce_id_width_p   = 4,
  parameter int lce_assoc_p      = 8,
  parameter int in_data_width_p  = 64,
  parameter int out_data_width_p = 512,
  parameter int master_p         = 0
) (
  input logic clk_i,
  input logic reset_i,
  bp_stream_to_lite_if.slave bus
);
  localparam int stream_words_lp  = out_data_width_p / in_data_width_p;
  localparam int in_data_bytes_lp = in_data_width_p / 8;
  localparam int cnt_width_lp     =
    (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1;
  localparam int in_lg_lp         = $clog2(in_data_bytes_lp);
  localparam int way_width_lp     =
    (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1;
  localparam int hdr_width_lp     =
    4 + paddr_width_p + 3 + lce_id_width_p + way_width_lp;
  localparam int size_lsb_lp      = 4 + paddr_width_p;
  localparam logic lp_master      = (master_p != 0);

  typedef enum logic {e_collect, e_full} state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic [cnt_width_lp-1:0] r_cnt;
  logic [cnt_width_lp-1:0] r_last;
  logic [hdr_width_lp-1:0] r_hdr;
  logic [stream_words_lp-1:0][in_data_width_p-1:0] r_data;
  logic [stream_words_lp-1:0][in_data_width_p-1:0] w_data;

  logic [3:0]              w_type;
  logic [2:0]              w_size;
  logic                    w_is_wr;
  logic                    w_multi;
  logic                    w_first;
  logic [cnt_width_lp-1:0] w_hdr_last;
  logic [cnt_width_lp-1:0] w_cur_last;
  logic                    w_done;
  logic                    w_yumi;
  logic                    w_v;

  assign w_type  = bus.mem_header_i[3:0];
  assign w_size  = bus.mem_header_i[size_lsb_lp +: 3];
  assign w_is_wr = (w_type == 4'd1) || (w_type == 4'd3);
  assign w_multi = (lp_master == w_is_wr);
  assign w_first = (r_cnt == '0);

  // Beat count is a power of two, kept as N-1 so N == stream_words fits
  assign w_hdr_last =
    (w_multi && ({29'b0, w_size} > 32'(in_lg_lp)))
      ? cnt_width_lp'((32'd1 << ({29'b0, w_size} - 32'(in_lg_lp))) - 32'd1)
      : '0;

  assign w_cur_last = w_first ? w_hdr_last : r_last;
  assign w_done     = w_yumi && (r_cnt == w_cur_last);

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= e_collect;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      e_collect: if (w_done)         w_state_nxt = e_full;
      e_full:    if (bus.mem_yumi_i) w_state_nxt = e_collect;
      default:                       w_state_nxt = e_collect;
    endcase
  end

  always_comb begin
    w_yumi = 1'b0;
    w_v    = 1'b0;
    unique case (r_state)
      e_collect: w_yumi = bus.mem_v_i && !reset_i;
      e_full:    w_v    = 1'b1;
      default:   w_yumi = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cnt <= '0;
    end else if (w_yumi) begin
      r_data[r_cnt] <= bus.mem_data_i;
      if (w_first) begin
        r_hdr  <= bus.mem_header_i;
        r_last <= w_hdr_last;
      end
      r_cnt <= w_done ? '0 : r_cnt + 1'b1;
    end
  end

  // N is a power of two, so k mod N reduces to a mask with N-1
  for (genvar k = 0; k < stream_words_lp; k++) begin : g_rep
    localparam logic [cnt_width_lp-1:0] lp_k = cnt_width_lp'(k);
    assign w_data[k] = r_data[lp_k & r_last];
  end

  assign bus.mem_yumi_o = w_yumi;
  assign bus.mem_v_o    = w_v;
  assign bus.mem_o      = {r_hdr, w_data};

`ifndef SYNTHESIS
  a_div: assert property (@(posedge clk_i)
    (out_data_width_p % in_data_width_p) == 0);
  a_size: assert property (@(posedge clk_i) disable iff (reset_i)
    (w_yumi && w_first) |->
      ((32'd1 << w_size) <= 32'(out_data_width_p / 8)));
  a_same: assert property (@(posedge clk_i) disable iff (reset_i)
    (w_yumi && !w_first) |->
      (w_type == r_hdr[3:0] && w_size == r_hdr[size_lsb_lp +: 3]));
  a_yumi: assert property (@(posedge clk_i) disable iff (reset_i)
    bus.mem_yumi_i |-> w_v);
`endif
endmodule

// File: tb/tb_bp_stream_to_lite.sv
// Randomized and directed checks of bp_stream_to_lite (in=64, out=512,
// master_p=1) against a message-level reference model.
module tb_bp_stream_to_lite;
  localparam int PA = 40;
  localparam int LI = 4;
  localparam int AS = 8;
  localparam int IW = 64;
  localparam int OW = 512;
  localparam int HW = 4 + PA + 3 + LI + $clog2(AS);
  localparam int PW = HW - PA - 7;
  localparam int MW = HW + OW;
  localparam int SW = OW / IW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  int ycnt = 0;
  int y0;
  int nb;
  logic [IW-1:0] beats [SW];
  logic [MW-1:0] exp_m;
  logic [MW-1:0] exp_2;
  logic [HW-1:0] h;
  logic [PA-1:0] a;

  always #5 clk = ~clk;

  bp_stream_to_lite_if #(
    .hdr_width_p(HW),
    .in_data_width_p(IW),
    .out_data_width_p(OW)
  ) bus ();

  bp_stream_to_lite #(
    .paddr_width_p(PA),
    .lce_id_width_p(LI),
    .lce_assoc_p(AS),
    .in_data_width_p(IW),
    .out_data_width_p(OW),
    .master_p(1)
  ) dut (
    .clk_i(clk),
    .reset_i(rst),
    .bus(bus.slave)
  );

  always @(negedge clk) if (bus.mem_yumi_o) ycnt++;

  task automatic chk(input string tag,
                     input logic [MW-1:0] got,
                     input logic [MW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t,
                                           input logic [PA-1:0] ad,
                                           input logic [2:0] s,
                                           input logic [PW-1:0] pl);
    return {pl, s, ad, t};
  endfunction

  // Command side: writes carry (1<<size)/8 beats (at least 1), others 1
  function automatic int n_beats(input logic [HW-1:0] hd);
    int n;
    if (!(hd[3:0] == 4'd1 || hd[3:0] == 4'd3)) return 1;
    n = (1 << hd[PA+6:PA+4]) / (IW / 8);
    return (n < 1) ? 1 : n;
  endfunction

  function automatic logic [MW-1:0] model(input logic [HW-1:0] hd,
                                          input int n);
    logic [OW-1:0] d;
    for (int k = 0; k < SW; k++) d[k*IW +: IW] = beats[k % n];
    return {hd, d};
  endfunction

  task automatic put_beat(input logic [HW-1:0] hd, input logic [IW-1:0] d);
    int t;
    t = 0;
    bus.mem_header_i = hd;
    bus.mem_data_i   = d;
    bus.mem_v_i      = 1'b1;
    @(negedge clk);
    while (!bus.mem_yumi_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("beat_acc", bus.mem_yumi_o, 1'b1);
    @(posedge clk);
    #1;
    bus.mem_v_i = 1'b0;
  endtask

  task automatic send(input logic [HW-1:0] hd, input int n, input int gap);
    logic [HW-1:0] hb;
    for (int i = 0; i < n; i++) begin
      hb = hd;
      hb[PA+3:4] = hd[PA+3:4] + PA'(8 * i);
      put_beat(hb, beats[i]);
      chk((i == n - 1) ? "v_o_last" : "v_o_mid", bus.mem_v_o, i == n - 1);
      if (i < n - 1) repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic take(input logic [MW-1:0] e, input int delay);
    chk("mem_o", bus.mem_o, e);
    repeat (delay) begin
      @(posedge clk);
      #1;
      chk("hold_o", bus.mem_o, e);
      chk("hold_v", bus.mem_v_o, 1'b1);
    end
    bus.mem_yumi_i = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_yumi_i = 1'b0;
    chk("v_o_clr", bus.mem_v_o, 1'b0);
  endtask

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: got timeout exp finish");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    bus.mem_header_i = '0;
    bus.mem_data_i   = '0;
    bus.mem_yumi_i   = 1'b0;
    bus.mem_v_i      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_yumi", bus.mem_yumi_o, 1'b0);
    chk("rst_v", bus.mem_v_o, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mem_v_i = 1'b0;
    chk("rst_v2", bus.mem_v_o, 1'b0);

    // 64B write, 8 beats
    for (int i = 0; i < SW; i++) beats[i] = IW'(i + 1);
    h = mk_hdr(4'd1, 40'h80000000, 3'd6, '0);
    exp_m = model(h, 8);
    send(h, 8, 0);
    chk("t1_addr", bus.mem_o[OW+4 +: PA], 40'h80000000);
    chk("t1_data", bus.mem_o[OW-1:0],
        {64'h8, 64'h7, 64'h6, 64'h5, 64'h4, 64'h3, 64'h2, 64'h1});
    take(exp_m, 0);

    // 64B read, single beat
    beats[0] = {$urandom, $urandom};
    h = mk_hdr(4'd0, 40'h12345678C0, 3'd6, 7'h55);
    exp_m = model(h, 1);
    send(h, 1, 0);
    chk("t2_hdr", bus.mem_o[MW-1:OW], h);
    take(exp_m, 0);

    // 8B write replicated
    beats[0] = 64'hDEADBEEF_CAFEF00D;
    h = mk_hdr(4'd3, 40'h100, 3'd3, 7'h01);
    exp_m = model(h, 1);
    send(h, 1, 0);
    chk("t3_rep", bus.mem_o[OW-1:0], {8{64'hDEADBEEF_CAFEF00D}});
    take(exp_m, 0);

    // 16B write with 3 idle cycles between beats
    beats[0] = 64'hAAAA_0000_1111_2222;
    beats[1] = 64'hBBBB_3333_4444_5555;
    h = mk_hdr(4'd1, 40'h2000, 3'd4, 7'h02);
    exp_m = model(h, 2);
    y0 = ycnt;
    send(h, 2, 3);
    chk("t4_ycnt", MW'(ycnt - y0), MW'(2));
    take(exp_m, 0);

    // Backpressure with next beat 0 waiting
    beats[0] = {$urandom, $urandom};
    h = mk_hdr(4'd2, 40'h3000, 3'd6, 7'h03);
    exp_m = model(h, 1);
    send(h, 1, 0);
    beats[0] = {$urandom, $urandom};
    h = mk_hdr(4'd0, 40'h4000, 3'd6, 7'h04);
    exp_2 = model(h, 1);
    bus.mem_header_i = h;
    bus.mem_data_i   = beats[0];
    bus.mem_v_i      = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_yumi", bus.mem_yumi_o, 1'b0);
      chk("bp_hold", bus.mem_o, exp_m);
      chk("bp_v", bus.mem_v_o, 1'b1);
      @(posedge clk);
      #1;
    end
    bus.mem_yumi_i = 1'b1;
    @(negedge clk);
    chk("bp_yumi_take", bus.mem_yumi_o, 1'b0);
    @(posedge clk);
    #1;
    bus.mem_yumi_i = 1'b0;
    @(negedge clk);
    chk("bp_acc", bus.mem_yumi_o, 1'b1);
    @(posedge clk);
    #1;
    bus.mem_v_i = 1'b0;
    chk("bp_v2", bus.mem_v_o, 1'b1);
    take(exp_2, 0);

    // Reset after 3 of 8 beats
    h = mk_hdr(4'd1, 40'h1000, 3'd6, 7'h05);
    for (int i = 0; i < 3; i++) put_beat(h, 64'hBAD0 + IW'(i));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mr_v", bus.mem_v_o, 1'b0);
    for (int i = 0; i < SW; i++) beats[i] = {$urandom, $urandom};
    h = mk_hdr(4'd1, 40'h20000040, 3'd6, 7'h06);
    exp_m = model(h, 8);
    send(h, 8, 0);
    chk("mr_addr", bus.mem_o[OW+4 +: PA], 40'h20000040);
    take(exp_m, 1);

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      a = PA'({$urandom, $urandom});
      a[5:0] = '0;
      h = mk_hdr(4'($urandom_range(0, 3)), a,
                 3'($urandom_range(0, 6)), PW'($urandom));
      nb = n_beats(h);
      for (int i = 0; i < SW; i++) beats[i] = {$urandom, $urandom};
      exp_m = model(h, nb);
      send(h, nb, $urandom_range(0, 2));
      take(exp_m, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
